// File: rtl/spi_slave_regs.sv
// spi_slave_regs: oversampled SPI slave with a small register file.
// Frame = R/W bit, address, then auto-incrementing data words.
module spi_slave_regs #(
  parameter int DATA_WIDTH  = 8,
  parameter int ADDR_WIDTH  = 7,
  parameter int NUM_REGS    = 16,
  parameter int CPOL        = 0,
  parameter int CPHA        = 0,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst_b,
  input  logic                  cs_b,
  input  logic                  sclk,
  input  logic                  mosi,
  output logic                  miso,
  output logic                  miso_oe,
  output logic                  wr_valid,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_WIDTH-1:0] hw_addr,
  output logic [DATA_WIDTH-1:0] hw_rdata
);

  localparam int MAXW = (ADDR_WIDTH > DATA_WIDTH) ?
                        ADDR_WIDTH : DATA_WIDTH;
  localparam int CW = $clog2(MAXW) + 1;
  localparam int IW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [ADDR_WIDTH:0] NREGS =
    (ADDR_WIDTH+1)'(NUM_REGS);
  localparam logic [ADDR_WIDTH-1:0] LAST =
    ADDR_WIDTH'(NUM_REGS - 1);
  localparam logic [ADDR_WIDTH-1:0] A_ONE = ADDR_WIDTH'(1);
  localparam logic [CW-1:0] C_ONE = CW'(1);
  localparam logic [CW-1:0] ALAST = CW'(ADDR_WIDTH - 1);
  localparam logic [CW-1:0] DLAST = CW'(DATA_WIDTH - 1);
  localparam logic IDLE_LVL = 1'(CPOL);
  localparam bit SAMP_FALL = (CPOL != CPHA);

  typedef enum logic [1:0] {IDLE, CMD, ADDR, DATA} state_t;

  logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
  logic sclk_s, cs_s, sclk_d, cs_d;
  logic sclk_rise, sclk_fall;
  logic samp_q, shft_q, fall_q, rise_q, mosi_q;

  state_t                state;
  logic                  rw;
  logic [CW-1:0]         cnt;
  logic [ADDR_WIDTH-1:0] addr, addr_nx, addr_inc;
  logic [DATA_WIDTH-1:0] rx_nx, tx;
  logic [DATA_WIDTH-1:0] rx;
  logic [DATA_WIDTH-1:0] rd_first, rd_next;
  logic [DATA_WIDTH-1:0] regs [NUM_REGS];

  function automatic logic in_rng(
    input logic [ADDR_WIDTH-1:0] a
  );
    return {1'b0, a} < NREGS;
  endfunction

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign cs_s      = cs_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_d;
  assign sclk_fall = ~sclk_s & sclk_d;
  assign miso_oe   = ~cs_s;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      sclk_sync <= {SYNC_STAGES{IDLE_LVL}};
      cs_sync   <= '1;
      mosi_sync <= '0;
      sclk_d    <= IDLE_LVL;
      cs_d      <= 1'b1;
      samp_q    <= 1'b0;
      shft_q    <= 1'b0;
      fall_q    <= 1'b0;
      rise_q    <= 1'b0;
      mosi_q    <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_b};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      sclk_d    <= sclk_s;
      cs_d      <= cs_s;
      samp_q    <= SAMP_FALL ? sclk_fall : sclk_rise;
      shft_q    <= SAMP_FALL ? sclk_rise : sclk_fall;
      fall_q    <= ~cs_s & cs_d;
      rise_q    <= cs_s & ~cs_d;
      mosi_q    <= mosi_sync[SYNC_STAGES-1];
    end
  end

  assign addr_nx  = ADDR_WIDTH'({addr, mosi_q});
  assign rx_nx    = DATA_WIDTH'({rx, mosi_q});
  assign addr_inc = (addr == LAST) ? '0 : addr + A_ONE;

  assign rd_first = in_rng(addr_nx) ?
                    regs[addr_nx[IW-1:0]] : '0;
  assign rd_next  = in_rng(addr_inc) ?
                    regs[addr_inc[IW-1:0]] : '0;
  assign hw_rdata = in_rng(hw_addr) ?
                    regs[hw_addr[IW-1:0]] : '0;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state    <= IDLE;
      rw       <= 1'b0;
      cnt      <= '0;
      addr     <= '0;
      rx       <= '0;
      tx       <= '0;
      miso     <= 1'b0;
      wr_valid <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
    end else begin
      wr_valid <= 1'b0;
      if (rise_q) begin
        state <= IDLE;
        cnt   <= '0;
        tx    <= '0;
        miso  <= 1'b0;
      end else begin
        unique case (state)
          IDLE: if (fall_q) begin
            state <= CMD;
            cnt   <= '0;
          end
          CMD: if (samp_q) begin
            rw    <= mosi_q;
            state <= ADDR;
            cnt   <= '0;
          end
          ADDR: if (samp_q) begin
            addr <= addr_nx;
            if (cnt == ALAST) begin
              state <= DATA;
              cnt   <= '0;
              // CPHA=0 must show the MSB before the first data sample
              if (rw) begin
                tx <= rd_first;
                if (CPHA == 0) miso <= rd_first[DATA_WIDTH-1];
              end
            end else begin
              cnt <= cnt + C_ONE;
            end
          end
          DATA: if (samp_q) begin
            rx <= rx_nx;
            if (cnt == DLAST) begin
              cnt  <= '0;
              addr <= addr_inc;
              if (!rw && in_rng(addr)) begin
                wr_valid <= 1'b1;
                wr_addr  <= addr;
                wr_data  <= rx_nx;
              end
              if (rw) begin
                tx <= rd_next;
                if (CPHA == 0) miso <= rd_next[DATA_WIDTH-1];
              end
            end else begin
              cnt <= cnt + C_ONE;
            end
          end else if (shft_q && rw) begin
            miso <= tx[DATA_WIDTH-1];
            tx   <= tx << 1;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // commit one cycle after the pulse so the pulse cycle reads old data
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) regs <= '{default: '0};
    else if (wr_valid) regs[wr_addr[IW-1:0]] <= wr_data;
  end

endmodule

// File: tb/tb_spi_slave_regs.sv
// tb_spi_slave_regs: four slaves (modes 0-3) driven by a bit-level
// SPI master; write events and read words checked via queues.
module tb_spi_slave_regs;

  localparam int HP = 80;

  logic       clk = 1'b0;
  logic       rst_b = 1'b0;
  logic       mosi = 1'b0;
  logic [3:0] cs_b = 4'b1111;
  logic [3:0] sclk = 4'b1100;
  logic [3:0] miso, miso_oe, wr_valid;
  logic [6:0] wr_addr [4];
  logic [7:0] wr_data [4];
  logic [6:0] hw_addr = '0;
  logic [7:0] hw_rdata [4];

  int errors = 0;
  int checks = 0;

  logic [16:0] wr_q [$];
  logic [7:0]  exp_rd_q [$];
  logic [7:0]  obs_q [$];
  logic [7:0]  wbuf [4];

  always #5 clk = ~clk;

  for (genvar m = 0; m < 4; m++) begin : g_dut
    spi_slave_regs #(
      .CPOL(m / 2),
      .CPHA(m % 2)
    ) u_dut (
      .clk(clk),
      .rst_b(rst_b),
      .cs_b(cs_b[m]),
      .sclk(sclk[m]),
      .mosi(mosi),
      .miso(miso[m]),
      .miso_oe(miso_oe[m]),
      .wr_valid(wr_valid[m]),
      .wr_addr(wr_addr[m]),
      .wr_data(wr_data[m]),
      .hw_addr(hw_addr),
      .hw_rdata(hw_rdata[m])
    );
  end

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // write-event monitor
  always @(negedge clk) begin
    for (int m = 0; m < 4; m++) begin
      if (wr_valid[m] === 1'b1) begin
        if (wr_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL wr_unexpected: mode %0d addr %0h data %0h",
                   m, wr_addr[m], wr_data[m]);
        end else begin
          check("wr_evt", {2'(m), wr_addr[m], wr_data[m]},
                wr_q.pop_front());
        end
      end
    end
  end

  // read-word monitor
  always @(negedge clk) begin
    if (obs_q.size() > 0 && exp_rd_q.size() > 0)
      check("rd_word", obs_q.pop_front(), exp_rd_q.pop_front());
  end

  task automatic xfer(input int m, input logic rw,
                      input logic [6:0] a, input int nb);
    logic       bits [64];
    logic       cpol, cpha, s, hdr, unstable;
    logic [7:0] word;
    int         n;
    cpol = 1'(m >> 1);
    cpha = 1'(m & 1);
    n = 8 + nb;
    bits[0] = rw;
    for (int i = 0; i < 7; i++) bits[1+i] = a[6-i];
    for (int i = 0; i < nb; i++) bits[8+i] = wbuf[i/8][7-(i%8)];
    hdr = 1'b0;
    unstable = 1'b0;
    word = '0;
    s = 1'b0;
    cs_b[m] = 1'b0;
    if (!cpha) mosi = bits[0];
    #HP;
    for (int i = 0; i < n; i++) begin
      if (cpha) mosi = bits[i];
      else s = miso[m];
      sclk[m] = ~cpol;
      if (!cpha) begin
        #15;
        unstable |= (miso[m] !== s);
        #(HP-15);
      end else begin
        #HP;
        s = miso[m];
      end
      sclk[m] = cpol;
      if (cpha) begin
        #15;
        unstable |= (miso[m] !== s);
        #(HP-15);
      end else begin
        if (i + 1 < n) mosi = bits[i+1];
        #HP;
      end
      if (i < 8) begin
        hdr |= s;
      end else begin
        word = {word[6:0], s};
        if (rw && (i - 8) % 8 == 7) obs_q.push_back(word);
      end
    end
    cs_b[m] = 1'b1;
    #(4*HP);
    if (rw) begin
      check("miso_hdr", hdr, 0);
      check("miso_stable", unstable, 0);
    end
  endtask

  task automatic wr1(input int m, input logic [6:0] a,
                     input logic [7:0] d);
    wbuf[0] = d;
    wr_q.push_back({2'(m), a, d});
    xfer(m, 1'b0, a, 8);
  endtask

  task automatic hw_chk(input int m, input logic [6:0] a,
                        input logic [7:0] d);
    hw_addr = a;
    #1;
    check("hw_rdata", hw_rdata[m], d);
  endtask

  initial begin
    #23;
    for (int m = 0; m < 4; m++)
      check("rst_out", {miso[m], miso_oe[m], wr_valid[m],
                        wr_addr[m], wr_data[m]}, 0);
    hw_chk(0, 7'd3, 8'h00);
    #30 rst_b = 1'b1;
    #50;

    // mode 0 single write, readback via host port and miso
    wr1(0, 7'd3, 8'hA5);
    hw_chk(0, 7'd3, 8'hA5);
    exp_rd_q.push_back(8'hA5);
    xfer(0, 1'b1, 7'd3, 8);
    exp_rd_q.push_back(8'h00);
    exp_rd_q.push_back(8'h00);
    exp_rd_q.push_back(8'h00);
    xfer(0, 1'b1, 7'd0, 24);
    for (int a = 0; a < 16; a++)
      hw_chk(0, 7'(a), (a == 3) ? 8'hA5 : 8'h00);

    // burst wrapping 15 -> 0 -> 1
    wbuf[0] = 8'h11;
    wbuf[1] = 8'h22;
    wbuf[2] = 8'h33;
    wr_q.push_back({2'd0, 7'd15, 8'h11});
    wr_q.push_back({2'd0, 7'd0, 8'h22});
    wr_q.push_back({2'd0, 7'd1, 8'h33});
    xfer(0, 1'b0, 7'd15, 24);
    hw_chk(0, 7'd15, 8'h11);
    hw_chk(0, 7'd0, 8'h22);
    hw_chk(0, 7'd1, 8'h33);
    exp_rd_q.push_back(8'h11);
    exp_rd_q.push_back(8'h22);
    exp_rd_q.push_back(8'h33);
    xfer(0, 1'b1, 7'd15, 24);

    // out-of-range write and read
    wbuf[0] = 8'h77;
    xfer(0, 1'b0, 7'h40, 8);
    exp_rd_q.push_back(8'h00);
    xfer(0, 1'b1, 7'h40, 8);
    hw_chk(0, 7'h40, 8'h00);
    hw_chk(0, 7'd0, 8'h22);

    // partial word aborted by cs_b
    wbuf[0] = 8'hFF;
    xfer(0, 1'b0, 7'd3, 5);
    hw_chk(0, 7'd3, 8'hA5);

    // all four modes, burst read crosses into an empty register
    for (int m = 0; m < 4; m++) begin
      wr1(m, 7'd7, 8'h3C);
      hw_chk(m, 7'd7, 8'h3C);
      exp_rd_q.push_back(8'h3C);
      exp_rd_q.push_back(8'h00);
      xfer(m, 1'b1, 7'd7, 16);
    end

    // reset in the data phase of a write
    wr1(0, 7'd2, 8'h5A);
    hw_chk(0, 7'd2, 8'h5A);
    wbuf[0] = 8'hC3;
    fork
      xfer(0, 1'b0, 7'd2, 4);
      begin
        #1700;
        rst_b = 1'b0;
      end
    join
    check("rst_mid_out", {miso[0], miso_oe[0], wr_valid[0],
                          wr_addr[0], wr_data[0]}, 0);
    hw_chk(0, 7'd2, 8'h00);
    #40 rst_b = 1'b1;
    #100;
    hw_chk(0, 7'd2, 8'h00);
    wr1(0, 7'd2, 8'h66);
    hw_chk(0, 7'd2, 8'h66);
    exp_rd_q.push_back(8'h66);
    xfer(0, 1'b1, 7'd2, 8);

    #200;
    check("wr_pending", wr_q.size(), 0);
    check("rd_pending", exp_rd_q.size(), 0);
    check("rd_extra", obs_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
